// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: d = a - b, LSB first, through one full-subtractor cell
// and a borrow flop, with valid/ready handshakes on the operand and result sides.
module serial_ripple_subtractor #(
  parameter int NB = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [NB-1:0] a,
  input  logic [NB-1:0] b,
  output logic          done_valid,
  input  logic          done_ready,
  output logic [NB-1:0] d,
  output logic          bout,
  output logic          busy
);

  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NB-1:0]   a_sh_q, a_sh_d;
  logic [NB-1:0]   b_sh_q, b_sh_d;
  logic [NB-1:0]   d_q, d_d;
  logic            bout_q, bout_d;
  logic            borrow_q, borrow_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            x_bit, y_bit, diff_bit, borrow_next;
  logic            last_bit;

  // Full-subtractor cell working on the current LSBs of the operand shift registers.
  always_comb begin
    x_bit       = a_sh_q[0];
    y_bit       = b_sh_q[0];
    diff_bit    = x_bit ^ y_bit ^ borrow_q;
    borrow_next = (~x_bit & y_bit) | (~x_bit & borrow_q) | (y_bit & borrow_q);
    last_bit    = (cnt_q == CW'(NB - 1));
  end

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_d      = d_q;
    bout_d   = bout_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        d_d      = {diff_bit, d_q[NB-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        borrow_d = borrow_next;
        // Counter is held on the final bit so it never wraps when NB is a power of two.
        if (last_bit) begin
          bout_d  = borrow_next;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DONE: begin
        if (done_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_q      <= '0;
      bout_q   <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_q      <= d_d;
      bout_q   <= bout_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign start_ready = (state_q == IDLE);
  assign done_valid  = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign d           = d_q;
  assign bout        = bout_q;

endmodule
